// File: rtl/ica_buf_pkg.sv
// Shared types and defaults for the FastICA sample buffer.
// Optional replay looping is enabled with the ICA_SBUF_LOOP_EN macro.
package ica_buf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        READ = 2'd2,
        DONE = 2'd3
    } sbuf_state_t;

    localparam int ICA_DATA_W = 26;
    localparam int ICA_DEPTH  = 128;
    localparam int ICA_CH     = 4;

    // LSB position of a channel lane inside a packed sample vector.
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/ica_sbuf_bank.sv
// One channel of sample storage: simple dual-port RAM with synchronous
// write and a registered read port that holds its value when not reading.
module ica_sbuf_bank
    import ica_buf_pkg::*;
#(
    parameter int DATA_W = ICA_DATA_W,
    parameter int DEPTH  = ICA_DEPTH,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register is reset so the buffer output is defined out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/ica_sample_buffer.sv
// Multi-channel FastICA sample store: fills one CH x DEPTH block, then replays it.
// Define ICA_SBUF_LOOP_EN to make replay loop until abort, pulsing pass_wrap per pass.
//
// state | meaning
// IDLE  | waiting for start; refused replay (no block stored) pulses err
// FILL  | writing qualified din at ptr, echoing it on dout
// READ  | issuing one read per enabled cycle at ptr
// DONE  | single-cycle completion, done=1
module ica_sample_buffer
    import ica_buf_pkg::*;
#(
    parameter int DATA_W = ICA_DATA_W,
    parameter int DEPTH  = ICA_DEPTH,
    parameter int CH     = ICA_CH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 wr_mode,
    input  logic                 abort,
    input  logic                 en,
    input  logic [CH*DATA_W-1:0] din,
    input  logic                 din_valid,
    output logic [CH*DATA_W-1:0] dout,
    output logic                 dout_valid,
    output logic [AW-1:0]        ptr,
    output logic                 done,
    output logic                 pass_wrap,
    output logic                 filled,
    output logic                 err
);

    sbuf_state_t           state;
    logic [CH*DATA_W-1:0]  echo;
    logic [CH*DATA_W-1:0]  rd_data;
    logic                  sel_echo;
    logic                  accept;
    logic                  issue;
    logic                  last;
    logic [AW-1:0]         ptr_next;

    assign accept   = (state == FILL) && en && din_valid && !abort;
    assign issue    = (state == READ) && en && !abort;
    assign last     = (ptr == AW'(DEPTH - 1));
    assign ptr_next = last ? '0 : ptr + AW'(1);
    assign dout     = sel_echo ? echo : rd_data;

    for (genvar c = 0; c < CH; c++) begin : g_bank
        ica_sbuf_bank #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .AW     (AW)
        ) u_bank (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (accept),
            .wr_addr (ptr),
            .wr_data (din[lane_lo(c, DATA_W) +: DATA_W]),
            .rd_en   (issue),
            .rd_addr (ptr),
            .rd_data (rd_data[lane_lo(c, DATA_W) +: DATA_W])
        );
    end

`ifndef ICA_SBUF_LOOP_EN
    assign pass_wrap = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            echo       <= '0;
            sel_echo   <= 1'b0;
            dout_valid <= 1'b0;
            done       <= 1'b0;
            filled     <= 1'b0;
            err        <= 1'b0;
`ifdef ICA_SBUF_LOOP_EN
            pass_wrap  <= 1'b0;
`endif
        end else begin
            dout_valid <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
`ifdef ICA_SBUF_LOOP_EN
            pass_wrap  <= 1'b0;
`endif
            if (abort) begin
                state <= IDLE;
                ptr   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (wr_mode) begin
                                state  <= FILL;
                                filled <= 1'b0;
                                ptr    <= '0;
                            end else if (filled) begin
                                state <= READ;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    FILL: begin
                        if (accept) begin
                            echo       <= din;
                            sel_echo   <= 1'b1;
                            dout_valid <= 1'b1;
                            ptr        <= ptr_next;
                            if (last) begin
                                state  <= DONE;
                                filled <= 1'b1;
                                done   <= 1'b1;
                            end
                        end
                    end
                    READ: begin
                        if (issue) begin
                            sel_echo   <= 1'b0;
                            dout_valid <= 1'b1;
                            ptr        <= ptr_next;
                            if (last) begin
`ifdef ICA_SBUF_LOOP_EN
                                pass_wrap <= 1'b1;
`else
                                state <= DONE;
                                done  <= 1'b1;
`endif
                            end
                        end
                    end
                    DONE: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ica_sample_buffer.sv
// Directed-plus-random bench for ica_sample_buffer with a block-level model.
// With ICA_SBUF_LOOP_EN defined the DUT is built with DEPTH=5 and replay loops 3 passes.
module tb_ica_sample_buffer;

    localparam int DATA_W = 26;
    localparam int CH     = 4;
`ifdef ICA_SBUF_LOOP_EN
    localparam int DEPTH  = 5;
    localparam bit LOOP   = 1'b1;
`else
    localparam int DEPTH  = 128;
    localparam bit LOOP   = 1'b0;
`endif
    localparam int AW       = $clog2(DEPTH);
    localparam int W        = CH * DATA_W;
    localparam int ABORT_AT = (DEPTH > 60) ? 60 : DEPTH / 2;
    localparam int RST_AT   = (DEPTH > 10) ? 10 : 2;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          wr_mode;
    logic          abort;
    logic          en;
    logic [W-1:0]  din;
    logic          din_valid;
    logic [W-1:0]  dout;
    logic          dout_valid;
    logic [AW-1:0] ptr;
    logic          done;
    logic          pass_wrap;
    logic          filled;
    logic          err;

    logic [W-1:0]  model [DEPTH];
    int            checks = 0;
    int            errors = 0;

    ica_sample_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CH     (CH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .wr_mode    (wr_mode),
        .abort      (abort),
        .en         (en),
        .din        (din),
        .din_valid  (din_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .ptr        (ptr),
        .done       (done),
        .pass_wrap  (pass_wrap),
        .filled     (filled),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] pattern(input int k);
        logic [W-1:0] v;
        for (int c = 0; c < CH; c++) v[c*DATA_W +: DATA_W] = DATA_W'(k * CH + c);
        return v;
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] v;
        for (int c = 0; c < CH; c++) v[c*DATA_W +: DATA_W] = DATA_W'($urandom);
        return v;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Replay request with nothing stored: err next cycle only, FSM stays idle.
    task automatic do_err(input string tag);
        start = 1'b1; wr_mode = 1'b0; en = 1'b1;
        @(negedge clk); start = 1'b0;
        check({tag, "_err"}, err, 1'b1);
        check({tag, "_valid"}, dout_valid, 1'b0);
        @(negedge clk);
        check({tag, "_err_clr"}, err, 1'b0);
        check({tag, "_ptr"}, ptr, '0);
        check({tag, "_idle"}, dout_valid, 1'b0);
    endtask

    // mode 0: consecutive pattern k*CH+c; mode 1: random data, din_valid every other cycle, random en gaps.
    task automatic do_fill(input int mode, input int abort_at);
        int k = 0;
        int cyc = 0;
        logic v, e;
        logic [W-1:0] d;
        start = 1'b1; wr_mode = 1'b1; en = 1'b1; din_valid = 1'b0;
        @(negedge clk); start = 1'b0;
        check("fill_clr", filled, 1'b0);
        while (k < DEPTH && cyc < 20 * DEPTH) begin
            v = (mode == 0) ? 1'b1 : (cyc % 2 == 0);
            e = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            d = (mode == 0) ? pattern(k) : rand_word();
            din = d; din_valid = v; en = e;
            if (k == abort_at) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0; din_valid = 1'b0; en = 1'b1;
                check("fill_abort_valid", dout_valid, 1'b0);
                check("fill_abort_ptr", ptr, '0);
                check("fill_abort_filled", filled, 1'b0);
                check("fill_abort_done", done, 1'b0);
                return;
            end
            @(negedge clk); cyc++;
            if (v && e) begin
                model[k] = d;
                check("fill_echo", dout, d);
                check("fill_echo_valid", dout_valid, 1'b1);
                k++;
            end else begin
                check("fill_gap_valid", dout_valid, 1'b0);
            end
            if (k < DEPTH) check("fill_done_early", done, 1'b0);
        end
        din_valid = 1'b0; en = 1'b1;
        check("fill_count", k, DEPTH);
        check("fill_done", done, 1'b1);
        check("fill_filled", filled, 1'b1);
        check("fill_ptr", ptr, '0);
        @(negedge clk);
        check("fill_done_pulse", done, 1'b0);
        check("fill_filled_hold", filled, 1'b1);
    endtask

    // Replay with an optional en-low pause before sample pause_at and optional reset before sample rst_at.
    task automatic do_read(input int pause_at, input int pause_len, input int rst_at);
        int k = 0;
        int cyc = 0;
        int paused = 0;
        int total;
        logic e;
        total = LOOP ? 3 * DEPTH : DEPTH;
        start = 1'b1; wr_mode = 1'b0; en = 1'b1;
        @(negedge clk); start = 1'b0;
        check("read_lead_valid", dout_valid, 1'b0);
        while (k < total && cyc < total + pause_len + 10) begin
            if (k == rst_at) begin
                #2 rst_n = 1'b0;
                #1;
                check("rst_valid", dout_valid, 1'b0);
                check("rst_ptr", ptr, '0);
                check("rst_filled", filled, 1'b0);
                check("rst_dout", dout, '0);
                @(negedge clk); rst_n = 1'b1;
                return;
            end
            e = !(k == pause_at && paused < pause_len);
            en = e;
            @(negedge clk); cyc++;
            if (e) begin
                check("read_data", dout, model[k % DEPTH]);
                check("read_valid", dout_valid, 1'b1);
                check("read_done", done, !LOOP && (k == DEPTH - 1));
                check("read_wrap", pass_wrap, LOOP && (k % DEPTH == DEPTH - 1));
                k++;
            end else begin
                paused++;
                check("pause_valid", dout_valid, 1'b0);
                if (k > 0) check("pause_hold", dout, model[(k - 1) % DEPTH]);
            end
        end
        en = 1'b1;
        check("read_count", k, total);
        check("pause_count", paused, (pause_at >= 0 && pause_at < total) ? pause_len : 0);
`ifdef ICA_SBUF_LOOP_EN
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        check("loop_abort_valid", dout_valid, 1'b0);
        check("loop_abort_ptr", ptr, '0);
        check("loop_abort_filled", filled, 1'b1);
        check("loop_abort_done", done, 1'b0);
`else
        @(negedge clk);
        check("read_done_pulse", done, 1'b0);
        check("read_end_valid", dout_valid, 1'b0);
        check("read_end_ptr", ptr, '0);
        check("read_end_filled", filled, 1'b1);
`endif
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; wr_mode = 1'b0; abort = 1'b0;
        en = 1'b0; din = '0; din_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_dout0", dout, '0);
        check("rst_dv0", dout_valid, 1'b0);
        check("rst_ptr0", ptr, '0);
        check("rst_done0", done, 1'b0);
        check("rst_wrap0", pass_wrap, 1'b0);
        check("rst_filled0", filled, 1'b0);
        check("rst_err0", err, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        do_err("empty");
        do_fill(0, -1);
        do_read(-1, 0, -1);
        do_fill(1, -1);
        do_read(DEPTH / 3, 5, -1);
        do_fill(0, ABORT_AT);
        do_err("after_abort");
        do_fill(1, -1);
        do_read(-1, 0, RST_AT);
        do_err("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
